ibex_compressed_realigner: RTL and testbench
============================================

Name: ibex_compressed_realigner

Overview:
- Sits between instruction fetch and the main decoder.
- Buffers raw 32-bit fetch words in a small FIFO and extracts 16- or 32-bit instructions at halfword granularity, including 32-bit instructions that straddle two words.
- Expands RV32C instructions to RV32 by instantiating ibex_compressed_decoder combinationally on the head instruction.
- Presents one instruction per cycle on a valid/ready interface, with PC, raw bits, compressed flag, illegal flag and bus-error flag.

Parameters:
- DEPTH, 3, number of 32-bit fetch words buffered (legal range 2..8).
- RESET_PC, 32'h0000_0080, PC of the first instruction after reset.
- OCC_W, $clog2(DEPTH+1), width of the occupancy output.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  discard all buffered state and restart at flush_addr_i
- flush_addr_i  in  32  new PC; bit 0 ignored
- fetch_valid_i  in  1  fetch word offered
- fetch_ready_o  out  1  FIFO can accept a word this cycle
- fetch_rdata_i  in  32  fetch word (little-endian halfwords)
- fetch_err_i  in  1  bus error on this word
- out_valid_o  out  1  head instruction complete
- out_ready_i  in  1  consumer takes the head instruction
- out_instr_o  out  32  expanded instruction
- out_raw_o  out  32  raw bits; upper 16 bits zero when compressed
- out_pc_o  out  32  PC of the head instruction
- out_is_compressed_o  out  1  head instruction is 16-bit
- out_illegal_o  out  1  expansion flagged illegal
- out_err_o  out  1  a word contributing to the head instruction had a bus error
- occupancy_o  out  OCC_W  words currently held

Behaviour:
- Storage:
  - DEPTH entries of {err, data[31:0]}.
  - Read pointer, write pointer, count, and halfword offset hw_off (0 = low half, 1 = high half of the head word).
  - Pointers wrap modulo DEPTH.
- Reset values:
  - FIFO empty, pc = RESET_PC, hw_off = RESET_PC[1].
  - Outputs: out_valid_o=0, fetch_ready_o=1, occupancy_o=0.
  - out_instr_o, out_raw_o, out_is_compressed_o, out_illegal_o and out_err_o are don't-care while out_valid_o=0; the bench does not check them.
- Push:
  - fetch_ready_o = (count < DEPTH) & ~flush_i. No same-cycle bypass of a pop.
  - A word is written on fetch_valid_i & fetch_ready_o.
  - Earliest out_valid_o is the cycle after the write, so latency is 1 cycle.
- Head extraction, all combinational from registered storage:
  - h0 = halfword at hw_off of the head word.
  - If h0[1:0] != 2'b11: the instruction is compressed and needs 1 halfword.
  - Otherwise it needs 2 halfwords:
    - hw_off=0: both halves come from the head word.
    - hw_off=1: the upper half comes from the low half of the next word.
- out_valid_o conditions:
  - Head word present and the instruction needs one halfword, or is 32-bit with hw_off=0.
  - Straddling case: also requires count >= 2.
  - Exception: if the head word has err=1, out_valid_o=1 immediately with out_err_o=1, without waiting for a second word.
  - out_valid_o=0 whenever flush_i=1.
- out_err_o = OR of err bits over the words the instruction spans.
- Pop on out_valid_o & out_ready_i:
  - pc += 2 (compressed) or 4, wrapping modulo 2^32.
  - hw_off and head pointer advance by the consumed halfwords: a word is freed when its last halfword is consumed.
  - A straddling pop frees one word and sets hw_off=1.
- Simultaneous push and pop in the same cycle are both honoured; count changes by the net amount.
- Flush:
  - Takes effect at the clock edge: count=0, pointers=0, pc=flush_addr_i with bit 0 forced to 0, hw_off=flush_addr_i[1].
  - Any pop or push in the flush cycle is discarded.
  - The next pushed word is the aligned word containing flush_addr_i.
- Reset asserted mid-operation: all state returns to reset values asynchronously.
- occupancy_o = count.

Optional Feature:
- Macro: IBEX_REALIGN_RV32E_EN.
- Defined: out_illegal_o is additionally set when a compressed instruction's expanded rd, rs1 or rs2 field (as applicable) is >= 16.
- Undefined: out_illegal_o equals the expander's illegal flag only.

Test Plan:
- Reset, then push 32'h4501_0505 (c.addi x10,1; c.li x10,0):
  - Cycle after push: out_valid_o=1, pc=0x80, out_instr_o=32'h0015_0513.
  - After pop: pc=0x82, out_instr_o=32'h0000_0513.
  - After second pop: out_valid_o=0 and occupancy_o=0.
- Straddle:
  - flush to 0x102, push word with upper half 16'h0293, check out_valid_o stays 0.
  - Push 32'h0000_0010; out_valid_o=1, out_raw_o=32'h0010_0293, out_pc_o=0x102.
- Full:
  - Push DEPTH words with out_ready_i=0; fetch_ready_o=0 and occupancy_o=DEPTH.
  - One compressed pop at hw_off=0 keeps fetch_ready_o=0.
  - A second pop frees the word; fetch_ready_o=1 next cycle.
- Error:
  - Push a word with fetch_err_i=1 whose high half begins a 32-bit instruction at hw_off=1.
  - out_valid_o=1 and out_err_o=1 with no second word pushed.
- Flush mid-stream:
  - 2 words buffered, assert flush_i with flush_addr_i=0x200 while out_ready_i=1.
  - Next cycle: occupancy_o=0, out_valid_o=0, and the next instruction reports pc=0x200.
- Illegal:
  - Push 16'h0000 (c.addi4spn, zero immediate); out_illegal_o=1.
  - With IBEX_REALIGN_RV32E_EN: c.li x20,1 (16'h4A05) gives out_illegal_o=1; without the macro, 0.

Source files
------------

// File: rtl/ibex_compressed_realigner.sv
// ibex_compressed_realigner
//   Buffers raw 32-bit fetch words and extracts one 16/32-bit instruction per
//   cycle at halfword granularity, including 32-bit instructions that straddle
//   two fetch words. Compressed instructions are expanded to RV32 by
//   ibex_compressed_decoder (defined in this file) before being presented.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush_i/flush_addr_i  drop all buffered state, restart at flush_addr_i
//   fetch_*               word-wide fetch input (valid/ready), per-word error
//   out_*                 head instruction (valid/ready): expanded, raw, pc,
//                         compressed / illegal / bus-error flags
//   occupancy_o           number of fetch words currently held
//
// Configuration
//   IBEX_REALIGN_RV32E_EN  when defined, a compressed instruction whose
//                          expanded register fields name x16..x31 is flagged
//                          illegal.

module ibex_compressed_decoder (
  input  logic [31:0] instr_i,
  output logic [31:0] instr_o,
  output logic        is_compressed_o,
  output logic        illegal_instr_o
);
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;

  assign is_compressed_o = (instr_i[1:0] != 2'b11);

  always_comb begin
    instr_o         = instr_i;
    illegal_instr_o = 1'b0;
    case (instr_i[1:0])
      2'b00: begin
        case (instr_i[15:13])
          3'b000: begin // c.addi4spn
            instr_o = {2'b0, instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6], 2'b00,
                       5'h02, 3'b000, 2'b01, instr_i[4:2], OPC_OP_IMM};
            if (instr_i[12:5] == 8'b0) illegal_instr_o = 1'b1;
          end
          3'b010: begin // c.lw
            instr_o = {5'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00, 2'b01, instr_i[9:7],
                       3'b010, 2'b01, instr_i[4:2], OPC_LOAD};
          end
          3'b110: begin // c.sw
            instr_o = {5'b0, instr_i[5], instr_i[12], 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                       3'b010, instr_i[11:10], instr_i[6], 2'b00, OPC_STORE};
          end
          default: illegal_instr_o = 1'b1;
        endcase
      end
      2'b01: begin
        case (instr_i[15:13])
          3'b000: begin // c.addi / c.nop
            instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], instr_i[11:7], 3'b0,
                       instr_i[11:7], OPC_OP_IMM};
          end
          3'b001, 3'b101: begin // c.jal (rd=x1) / c.j (rd=x0)
            instr_o = {instr_i[12], instr_i[8], instr_i[10:9], instr_i[6], instr_i[7], instr_i[2],
                       instr_i[11], instr_i[5:3], {9{instr_i[12]}}, 4'b0, ~instr_i[15], OPC_JAL};
          end
          3'b010: begin // c.li
            instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 5'b0, 3'b0,
                       instr_i[11:7], OPC_OP_IMM};
          end
          3'b011: begin // c.lui, or c.addi16sp when rd=x2
            instr_o = {{15{instr_i[12]}}, instr_i[6:2], instr_i[11:7], OPC_LUI};
            if (instr_i[11:7] == 5'h02) begin
              instr_o = {{3{instr_i[12]}}, instr_i[4:3], instr_i[5], instr_i[2], instr_i[6], 4'b0,
                         5'h02, 3'b000, 5'h02, OPC_OP_IMM};
            end
            if ({instr_i[12], instr_i[6:2]} == 6'b0) illegal_instr_o = 1'b1;
          end
          3'b100: begin
            case (instr_i[11:10])
              2'b00, 2'b01: begin // c.srli / c.srai
                instr_o = {1'b0, instr_i[10], 5'b0, instr_i[6:2], 2'b01, instr_i[9:7], 3'b101,
                           2'b01, instr_i[9:7], OPC_OP_IMM};
                if (instr_i[12]) illegal_instr_o = 1'b1;
              end
              2'b10: begin // c.andi
                instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 2'b01, instr_i[9:7], 3'b111,
                           2'b01, instr_i[9:7], OPC_OP_IMM};
              end
              default: begin // c.sub / c.xor / c.or / c.and
                case ({instr_i[12], instr_i[6:5]})
                  3'b000: instr_o = {2'b01, 5'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7], 3'b000,
                                     2'b01, instr_i[9:7], OPC_OP};
                  3'b001: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7], 3'b100,
                                     2'b01, instr_i[9:7], OPC_OP};
                  3'b010: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7], 3'b110,
                                     2'b01, instr_i[9:7], OPC_OP};
                  3'b011: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7], 3'b111,
                                     2'b01, instr_i[9:7], OPC_OP};
                  default: illegal_instr_o = 1'b1; // RV64-only encodings
                endcase
              end
            endcase
          end
          default: begin // c.beqz / c.bnez
            instr_o = {{4{instr_i[12]}}, instr_i[6:5], instr_i[2], 5'b0, 2'b01, instr_i[9:7],
                       2'b00, instr_i[13], instr_i[11:10], instr_i[4:3], instr_i[12], OPC_BRANCH};
          end
        endcase
      end
      2'b10: begin
        case (instr_i[15:13])
          3'b000: begin // c.slli
            instr_o = {7'b0, instr_i[6:2], instr_i[11:7], 3'b001, instr_i[11:7], OPC_OP_IMM};
            if (instr_i[12]) illegal_instr_o = 1'b1;
          end
          3'b010: begin // c.lwsp
            instr_o = {4'b0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00, 5'h02, 3'b010,
                       instr_i[11:7], OPC_LOAD};
            if (instr_i[11:7] == 5'b0) illegal_instr_o = 1'b1;
          end
          3'b100: begin
            if (!instr_i[12]) begin
              if (instr_i[6:2] != 5'b0) begin // c.mv
                instr_o = {7'b0, instr_i[6:2], 5'b0, 3'b0, instr_i[11:7], OPC_OP};
              end else begin // c.jr
                instr_o = {12'b0, instr_i[11:7], 3'b0, 5'b0, OPC_JALR};
                if (instr_i[11:7] == 5'b0) illegal_instr_o = 1'b1;
              end
            end else begin
              if (instr_i[6:2] != 5'b0) begin // c.add
                instr_o = {7'b0, instr_i[6:2], instr_i[11:7], 3'b0, instr_i[11:7], OPC_OP};
              end else if (instr_i[11:7] == 5'b0) begin // c.ebreak
                instr_o = 32'h0010_0073;
              end else begin // c.jalr
                instr_o = {12'b0, instr_i[11:7], 3'b000, 5'b00001, OPC_JALR};
              end
            end
          end
          3'b110: begin // c.swsp
            instr_o = {4'b0, instr_i[8:7], instr_i[12], instr_i[6:2], 5'h02, 3'b010,
                       instr_i[11:9], 2'b00, OPC_STORE};
          end
          default: illegal_instr_o = 1'b1;
        endcase
      end
      default: instr_o = instr_i; // already 32-bit
    endcase
  end
endmodule

module ibex_compressed_realigner #(
  parameter int unsigned DEPTH    = 3,
  parameter logic [31:0] RESET_PC = 32'h0000_0080,
  parameter int unsigned OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [31:0]      flush_addr_i,
  input  logic             fetch_valid_i,
  output logic             fetch_ready_o,
  input  logic [31:0]      fetch_rdata_i,
  input  logic             fetch_err_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_instr_o,
  output logic [31:0]      out_raw_o,
  output logic [31:0]      out_pc_o,
  output logic             out_is_compressed_o,
  output logic             out_illegal_o,
  output logic             out_err_o,
  output logic [OCC_W-1:0] occupancy_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d, wptr_q, wptr_d, rptr_nxt;
  logic [OCC_W-1:0]   count_q, count_d;
  logic               hw_off_q, hw_off_d;
  logic [31:0]        pc_q, pc_d;

  entry_t      head, nxt;
  logic [15:0] h0, h1;
  logic        is_comp, straddle, have_two, push, pop, free_word;
  logic [31:0] raw, dec_instr;
  logic        dec_comp, dec_illegal;
  logic        unused_flush_lsb;

  assign unused_flush_lsb = flush_addr_i[0];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Head extraction; nxt is only meaningful when a second word is held.
  assign rptr_nxt = ptr_inc(rptr_q);
  assign head     = mem_q[rptr_q];
  assign nxt      = mem_q[rptr_nxt];
  assign h0       = hw_off_q ? head.data[31:16] : head.data[15:0];
  assign h1       = hw_off_q ? nxt.data[15:0]   : head.data[31:16];
  assign is_comp  = (h0[1:0] != 2'b11);
  assign straddle = ~is_comp & hw_off_q;
  assign have_two = (count_q >= OCC_W'(2));
  assign raw      = is_comp ? {16'b0, h0} : {h1, h0};

  ibex_compressed_decoder u_cdec (
    .instr_i         (raw),
    .instr_o         (dec_instr),
    .is_compressed_o (dec_comp),
    .illegal_instr_o (dec_illegal)
  );

`ifdef IBEX_REALIGN_RV32E_EN
  // Register fields the expanded opcode actually uses, checked against x16+.
  function automatic logic rv32e_bad(input logic [31:0] i);
    logic rd_hi, rs1_hi, rs2_hi;
    rd_hi  = i[11];
    rs1_hi = i[19];
    rs2_hi = i[24];
    case (i[6:0])
      7'h13, 7'h03: return rd_hi | rs1_hi;
      7'h33:        return rd_hi | rs1_hi | rs2_hi;
      7'h23, 7'h63: return rs1_hi | rs2_hi;
      7'h6f, 7'h37: return rd_hi;
      7'h67:        return rd_hi | rs1_hi;
      default:      return 1'b0;
    endcase
  endfunction
  assign out_illegal_o = dec_illegal | (dec_comp & rv32e_bad(dec_instr));
`else
  assign out_illegal_o = dec_illegal;
`endif

  // An errored head word is released immediately: waiting for its partner
  // could stall forever if fetch stops after the fault.
  assign out_valid_o         = ~flush_i & (count_q != '0) & (~straddle | have_two | head.err);
  assign out_err_o           = head.err | (straddle & have_two & nxt.err);
  assign out_instr_o         = dec_instr;
  assign out_raw_o           = raw;
  assign out_pc_o            = pc_q;
  assign out_is_compressed_o = dec_comp;
  assign occupancy_o         = count_q;

  assign fetch_ready_o = (count_q < OCC_W'(DEPTH)) & ~flush_i;
  assign push          = fetch_valid_i & fetch_ready_o;
  assign pop           = out_valid_o & out_ready_i;
  // A compressed pop at the low half leaves the word in place; everything
  // else consumes the head word's last halfword.
  assign free_word     = ~is_comp | hw_off_q;

  always_comb begin
    mem_d    = mem_q;
    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    count_d  = count_q;
    hw_off_d = hw_off_q;
    pc_d     = pc_q;
    if (flush_i) begin
      rptr_d   = '0;
      wptr_d   = '0;
      count_d  = '0;
      hw_off_d = flush_addr_i[1];
      pc_d     = {flush_addr_i[31:1], 1'b0};
    end else begin
      if (push) begin
        mem_d[wptr_q] = {fetch_err_i, fetch_rdata_i};
        wptr_d        = ptr_inc(wptr_q);
      end
      if (pop) begin
        pc_d     = pc_q + (is_comp ? 32'd2 : 32'd4);
        hw_off_d = is_comp ? ~hw_off_q : hw_off_q;
        if (free_word) rptr_d = rptr_nxt;
      end
      count_d = count_q + OCC_W'(push) - OCC_W'(pop & free_word);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
      hw_off_q <= RESET_PC[1];
      pc_q     <= RESET_PC;
    end else begin
      mem_q    <= mem_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      hw_off_q <= hw_off_d;
      pc_q     <= pc_d;
    end
  end
endmodule

// File: tb/tb_ibex_compressed_realigner.sv
module tb_ibex_compressed_realigner;
  localparam int DEPTH = 3;
  localparam int OCC_W = $clog2(DEPTH + 1);

`ifdef IBEX_REALIGN_RV32E_EN
  localparam logic EXP_E_ILL = 1'b1;
`else
  localparam logic EXP_E_ILL = 1'b0;
`endif

  logic             clk, rst_n;
  logic             flush_i;
  logic [31:0]      flush_addr_i;
  logic             fetch_valid_i, fetch_ready_o, fetch_err_i;
  logic [31:0]      fetch_rdata_i;
  logic             out_valid_o, out_ready_i;
  logic [31:0]      out_instr_o, out_raw_o, out_pc_o;
  logic             out_is_compressed_o, out_illegal_o, out_err_o;
  logic [OCC_W-1:0] occupancy_o;

  int n_tests = 0;
  int n_fail  = 0;

  ibex_compressed_realigner #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0080)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush_i             (flush_i),
    .flush_addr_i        (flush_addr_i),
    .fetch_valid_i       (fetch_valid_i),
    .fetch_ready_o       (fetch_ready_o),
    .fetch_rdata_i       (fetch_rdata_i),
    .fetch_err_i         (fetch_err_i),
    .out_valid_o         (out_valid_o),
    .out_ready_i         (out_ready_i),
    .out_instr_o         (out_instr_o),
    .out_raw_o           (out_raw_o),
    .out_pc_o            (out_pc_o),
    .out_is_compressed_o (out_is_compressed_o),
    .out_illegal_o       (out_illegal_o),
    .out_err_o           (out_err_o),
    .occupancy_o         (occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    fetch_valid_i = 1'b1;
    fetch_rdata_i = d;
    fetch_err_i   = e;
    tick();
    fetch_valid_i = 1'b0;
    fetch_err_i   = 1'b0;
  endtask

  task automatic pop();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic flush(input logic [31:0] a);
    flush_i      = 1'b1;
    flush_addr_i = a;
    tick();
    flush_i      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; flush_i = 1'b0; flush_addr_i = '0;
    fetch_valid_i = 1'b0; fetch_rdata_i = '0; fetch_err_i = 1'b0; out_ready_i = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid_o), 0);
    chk("rst_fready", 32'(fetch_ready_o), 1);
    chk("rst_occ", 32'(occupancy_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_pc", out_pc_o, 32'h80);

    // Two compressed instructions in one word
    push(32'h4501_0505, 1'b0);
    chk("c1_valid", 32'(out_valid_o), 1);
    chk("c1_pc", out_pc_o, 32'h80);
    chk("c1_instr", out_instr_o, 32'h0015_0513);
    chk("c1_raw", out_raw_o, 32'h0000_0505);
    chk("c1_comp", 32'(out_is_compressed_o), 1);
    chk("c1_occ", 32'(occupancy_o), 1);
    pop();
    chk("c2_valid", 32'(out_valid_o), 1);
    chk("c2_pc", out_pc_o, 32'h82);
    chk("c2_instr", out_instr_o, 32'h0000_0513);
    pop();
    chk("c3_valid", 32'(out_valid_o), 0);
    chk("c3_occ", 32'(occupancy_o), 0);
    chk("c3_fready", 32'(fetch_ready_o), 1);

    // Straddling 32-bit instruction
    flush(32'h102);
    chk("s_pc0", out_pc_o, 32'h102);
    chk("s_occ0", 32'(occupancy_o), 0);
    push(32'h0293_0001, 1'b0);
    chk("s_wait", 32'(out_valid_o), 0);
    chk("s_occ1", 32'(occupancy_o), 1);
    push(32'h0000_0010, 1'b0);
    chk("s_valid", 32'(out_valid_o), 1);
    chk("s_raw", out_raw_o, 32'h0010_0293);
    chk("s_instr", out_instr_o, 32'h0010_0293);
    chk("s_pc", out_pc_o, 32'h102);
    chk("s_comp", 32'(out_is_compressed_o), 0);
    chk("s_err", 32'(out_err_o), 0);
    chk("s_ill", 32'(out_illegal_o), 0);
    pop();
    // Remaining high half of word 2 is 16'h0000: c.addi4spn with zero imm
    chk("ill_occ", 32'(occupancy_o), 1);
    chk("ill_pc", out_pc_o, 32'h106);
    chk("ill_valid", 32'(out_valid_o), 1);
    chk("ill_comp", 32'(out_is_compressed_o), 1);
    chk("ill_flag", 32'(out_illegal_o), 1);
    pop();
    chk("s_end_valid", 32'(out_valid_o), 0);
    chk("s_end_occ", 32'(occupancy_o), 0);

    // Fill to DEPTH, then overflow attempt
    flush(32'h300);
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h4501_0505; tick();
    fetch_rdata_i = 32'h4A05_4501; tick();
    fetch_rdata_i = 32'h0001_0001; tick();
    chk("f_fready", 32'(fetch_ready_o), 0);
    chk("f_occ", 32'(occupancy_o), DEPTH);
    fetch_rdata_i = 32'hDEAD_BEEF; tick();
    fetch_valid_i = 1'b0;
    chk("f_occ_ovf", 32'(occupancy_o), DEPTH);
    chk("f_head", out_instr_o, 32'h0015_0513);
    pop();
    chk("f_pop1_fready", 32'(fetch_ready_o), 0);
    chk("f_pop1_occ", 32'(occupancy_o), DEPTH);
    chk("f_pop1_pc", out_pc_o, 32'h302);
    pop();
    chk("f_pop2_fready", 32'(fetch_ready_o), 1);
    chk("f_pop2_occ", 32'(occupancy_o), 2);
    chk("f_pop2_pc", out_pc_o, 32'h304);
    chk("f_pop2_instr", out_instr_o, 32'h0000_0513);
    pop();
    chk("e_pc", out_pc_o, 32'h306);
    chk("e_instr", out_instr_o, 32'h0010_0A13);
    chk("e_ill", 32'(out_illegal_o), 32'(EXP_E_ILL));
    pop();
    chk("w2_occ", 32'(occupancy_o), 1);
    chk("w2_instr", out_instr_o, 32'h0000_0013);
    // Simultaneous push and pop (pop does not free the word)
    fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0001_0001; out_ready_i = 1'b1;
    tick();
    fetch_valid_i = 1'b0; out_ready_i = 1'b0;
    chk("pp_occ", 32'(occupancy_o), 2);
    chk("pp_pc", out_pc_o, 32'h30A);

    // Flush with two words buffered and consumer ready
    flush_i = 1'b1; flush_addr_i = 32'h200; out_ready_i = 1'b1;
    #1;
    chk("fl_valid_during", 32'(out_valid_o), 0);
    chk("fl_fready_during", 32'(fetch_ready_o), 0);
    tick();
    flush_i = 1'b0; out_ready_i = 1'b0;
    chk("fl_occ", 32'(occupancy_o), 0);
    chk("fl_valid", 32'(out_valid_o), 0);
    push(32'h0001_0505, 1'b0);
    chk("fl_next_valid", 32'(out_valid_o), 1);
    chk("fl_next_pc", out_pc_o, 32'h200);
    chk("fl_next_instr", out_instr_o, 32'h0015_0513);

    // Errored word at hw_off=1 starting a 32-bit instruction
    flush(32'h402);
    push(32'h0293_0000, 1'b1);
    chk("er_valid", 32'(out_valid_o), 1);
    chk("er_err", 32'(out_err_o), 1);
    chk("er_comp", 32'(out_is_compressed_o), 0);
    chk("er_pc", out_pc_o, 32'h402);
    pop();
    chk("er_pop_occ", 32'(occupancy_o), 0);
    chk("er_pop_pc", out_pc_o, 32'h406);
    chk("er_pop_valid", 32'(out_valid_o), 0);

    // Error on the second word of a straddle
    flush(32'h502);
    push(32'h0293_0000, 1'b0);
    chk("er2_wait", 32'(out_valid_o), 0);
    push(32'h0000_0010, 1'b1);
    chk("er2_valid", 32'(out_valid_o), 1);
    chk("er2_err", 32'(out_err_o), 1);
    pop();
    chk("er2_tail_pc", out_pc_o, 32'h506);
    chk("er2_tail_err", 32'(out_err_o), 1);
    pop();

    // Asynchronous reset mid-operation
    push(32'h0001_0001, 1'b0);
    chk("ar_occ_pre", 32'(occupancy_o), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ar_occ", 32'(occupancy_o), 0);
    chk("ar_valid", 32'(out_valid_o), 0);
    chk("ar_fready", 32'(fetch_ready_o), 1);
    chk("ar_pc", out_pc_o, 32'h80);
    #2 rst_n = 1'b1;
    push(32'h4501_0505, 1'b0);
    chk("ar_post_valid", 32'(out_valid_o), 1);
    chk("ar_post_instr", out_instr_o, 32'h0015_0513);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
